// File: rtl/uart_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_sched_pkg
// Purpose  : Shared FSM encodings, tag nibble and txd control-bit positions
//            for the UART transmit scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package uart_sched_pkg;

    localparam int IDXW = 4;

    localparam logic [3:0] TAG_HI = 4'hA;

    localparam int CTRL_START = 0;
    localparam int CTRL_STOP2 = 1;
    localparam int CTRL_PODD  = 2;
    localparam int CTRL_PEN   = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_LATCH = 3'd2,
        S_WAIT  = 3'd3,
        S_ACK   = 3'd4
    } state_t;

    typedef enum logic {
        SEL_TAG  = 1'b0,
        SEL_DATA = 1'b1
    } sel_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin search; first requester after ptr wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]  req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_vld
);

    // Channels above ptr take precedence, then wrap around to the lowest index.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int n = 0; n < NCH; n++) begin
            if (!gnt_vld && req[n] && (IDXW'(n) > ptr)) begin
                gnt_vld = 1'b1;
                gnt_idx = IDXW'(n);
            end
        end
        for (int n = 0; n < NCH; n++) begin
            if (!gnt_vld && req[n]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDXW'(n);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : Round-robin sharing of one UART transmitter among NCH channels,
//            tag+data framing, per-byte watchdog abort.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int TAG_EN  = 1,
    parameter int TMO_CYC = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     req_i,
    input  logic [NCH*8-1:0]   data_i,
    output logic [NCH-1:0]     ack_o,
    input  logic               cfg_par_en_i,
    input  logic               cfg_par_odd_i,
    input  logic               cfg_stop2_i,
    output logic [7:0]         tx_data_o,
    output logic [3:0]         tx_ctrl_o,
    input  logic               tx_ready_i,
    input  logic               tx_done_i,
    output logic               busy_o,
    output logic [IDXW-1:0]    grant_o,
    output logic               err_o,
    output logic [IDXW-1:0]    err_ch_o
);

    localparam logic [15:0] c_wdLast = 16'(TMO_CYC - 1);

    state_t          r_state,    w_stateNext;
    logic [IDXW-1:0] r_ptr,      w_ptrNext;
    logic [IDXW-1:0] r_grant,    w_grantNext;
    sel_t            r_sel,      w_selNext;
    logic [7:0]      r_data,     w_dataNext;
    logic            r_cfgPen,   w_cfgPenNext;
    logic            r_cfgPodd,  w_cfgPoddNext;
    logic            r_cfgStop2, w_cfgStop2Next;
    logic [15:0]     r_wdCnt,    w_wdCntNext;
    logic [7:0]      r_txData,   w_txDataNext;
    logic            r_txStart,  w_txStartNext;
    logic [NCH-1:0]  r_ack,      w_ackNext;
    logic            r_busy,     w_busyNext;
    logic            r_err,      w_errNext;
    logic [IDXW-1:0] r_errCh,    w_errChNext;

    logic [IDXW-1:0] w_gntIdx;
    logic            w_gntVld;
    logic [7:0]      w_gntByte;
    logic            w_wdTmo;

    rr_arbiter #(
        .NCH     (NCH)
    ) u_arb (
        .req     (req_i),
        .ptr     (r_ptr),
        .gnt_idx (w_gntIdx),
        .gnt_vld (w_gntVld)
    );

    always_comb begin
        w_gntByte = 8'h00;
        for (int n = 0; n < NCH; n++) begin
            if (w_gntIdx == IDXW'(n)) begin
                w_gntByte = data_i[8*n +: 8];
            end
        end
    end

    assign w_wdTmo = (r_wdCnt == c_wdLast);

    always_comb begin
        w_stateNext    = r_state;
        w_ptrNext      = r_ptr;
        w_grantNext    = r_grant;
        w_selNext      = r_sel;
        w_dataNext     = r_data;
        w_cfgPenNext   = r_cfgPen;
        w_cfgPoddNext  = r_cfgPodd;
        w_cfgStop2Next = r_cfgStop2;
        w_wdCntNext    = r_wdCnt;
        w_txDataNext   = r_txData;
        w_txStartNext  = 1'b0;
        w_ackNext      = '0;
        w_errNext      = 1'b0;
        w_errChNext    = r_errCh;

        // Watchdog outranks any handshake progress in the same cycle.
        if (((r_state == S_LATCH) || (r_state == S_WAIT)) && w_wdTmo) begin
            w_errNext   = 1'b1;
            w_errChNext = r_grant;
            w_ptrNext   = r_grant;
            w_stateNext = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gntVld) begin
                        w_grantNext    = w_gntIdx;
                        w_dataNext     = w_gntByte;
                        w_cfgPenNext   = cfg_par_en_i;
                        w_cfgPoddNext  = cfg_par_odd_i;
                        w_cfgStop2Next = cfg_stop2_i;
                        w_selNext      = (TAG_EN != 0) ? SEL_TAG : SEL_DATA;
                        w_txDataNext   = (TAG_EN != 0) ? {TAG_HI, w_gntIdx} : w_gntByte;
                        w_txStartNext  = 1'b1;
                        w_stateNext    = S_START;
                    end
                end
                S_START: begin
                    w_wdCntNext = '0;
                    w_stateNext = S_LATCH;
                end
                S_LATCH: begin
                    w_wdCntNext = r_wdCnt + 16'd1;
                    if (!tx_ready_i) begin
                        w_stateNext = S_WAIT;
                    end
                end
                S_WAIT: begin
                    w_wdCntNext = r_wdCnt + 16'd1;
                    if (tx_done_i) begin
                        if (r_sel == SEL_TAG) begin
                            w_selNext     = SEL_DATA;
                            w_txDataNext  = r_data;
                            w_txStartNext = 1'b1;
                            w_stateNext   = S_START;
                        end else begin
                            for (int n = 0; n < NCH; n++) begin
                                w_ackNext[n] = (r_grant == IDXW'(n));
                            end
                            w_stateNext = S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    w_ptrNext   = r_grant;
                    w_stateNext = S_IDLE;
                end
                default: w_stateNext = S_IDLE;
            endcase
        end

        w_busyNext = (w_stateNext != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= IDXW'(NCH - 1);
            r_grant    <= '0;
            r_sel      <= SEL_TAG;
            r_data     <= '0;
            r_cfgPen   <= 1'b0;
            r_cfgPodd  <= 1'b0;
            r_cfgStop2 <= 1'b0;
            r_wdCnt    <= '0;
            r_txData   <= '0;
            r_txStart  <= 1'b0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_errCh    <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_ptr      <= w_ptrNext;
            r_grant    <= w_grantNext;
            r_sel      <= w_selNext;
            r_data     <= w_dataNext;
            r_cfgPen   <= w_cfgPenNext;
            r_cfgPodd  <= w_cfgPoddNext;
            r_cfgStop2 <= w_cfgStop2Next;
            r_wdCnt    <= w_wdCntNext;
            r_txData   <= w_txDataNext;
            r_txStart  <= w_txStartNext;
            r_ack      <= w_ackNext;
            r_busy     <= w_busyNext;
            r_err      <= w_errNext;
            r_errCh    <= w_errChNext;
        end
    end

    always_comb begin
        tx_ctrl_o             = '0;
        tx_ctrl_o[CTRL_START] = r_txStart;
        tx_ctrl_o[CTRL_STOP2] = r_cfgStop2;
        tx_ctrl_o[CTRL_PODD]  = r_cfgPodd;
        tx_ctrl_o[CTRL_PEN]   = r_cfgPen;
    end

    assign tx_data_o = r_txData;
    assign ack_o     = r_ack;
    assign busy_o    = r_busy;
    assign grant_o   = r_grant;
    assign err_o     = r_err;
    assign err_ch_o  = r_errCh;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Purpose  : Self-checking bench for uart_tx_sched with a behavioural txd.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_i;
    logic [31:0] data_i;
    logic [3:0]  ack_o;
    logic        cfg_par_en_i, cfg_par_odd_i, cfg_stop2_i;
    logic [7:0]  tx_data_o;
    logic [3:0]  tx_ctrl_o;
    logic        tx_ready_i, tx_done_i;
    logic        busy_o;
    logic [3:0]  grant_o;
    logic        err_o;
    logic [3:0]  err_ch_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mdlCnt = 0;
    bit mdlHang = 0;
    int doneCyc = -1;
    int startCyc = -1;
    int ackCount = 0;
    logic [7:0] byteLog[$];

    typedef struct {
        logic [3:0] req;
        int         ch;
        logic [7:0] tag;
        logic [7:0] dat;
    } vec_t;

    vec_t vecs[12];

    uart_tx_sched #(
        .NCH           (4),
        .TAG_EN        (1),
        .TMO_CYC       (1000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .data_i        (data_i),
        .ack_o         (ack_o),
        .cfg_par_en_i  (cfg_par_en_i),
        .cfg_par_odd_i (cfg_par_odd_i),
        .cfg_stop2_i   (cfg_stop2_i),
        .tx_data_o     (tx_data_o),
        .tx_ctrl_o     (tx_ctrl_o),
        .tx_ready_i    (tx_ready_i),
        .tx_done_i     (tx_done_i),
        .busy_o        (busy_o),
        .grant_o       (grant_o),
        .err_o         (err_o),
        .err_ch_o      (err_ch_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // txd model: drops ready after a start, pulses done three cycles later.
    initial begin
        tx_ready_i = 1'b1;
        tx_done_i  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_ready_i = 1'b1;
                tx_done_i  = 1'b0;
                mdlCnt     = 0;
            end else begin
                tx_done_i = 1'b0;
                if (tx_ctrl_o[0]) begin
                    tx_ready_i = 1'b0;
                    mdlCnt     = 3;
                end else if (mdlCnt > 0) begin
                    mdlCnt = mdlCnt - 1;
                    if (mdlCnt == 0 && !mdlHang) begin
                        tx_done_i  = 1'b1;
                        tx_ready_i = 1'b1;
                        doneCyc    = cyc;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tx_ctrl_o[0]) begin
                    byteLog.push_back(tx_data_o);
                    startCyc = cyc;
                end
                if (ack_o != 4'b0000) ackCount = ackCount + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // kind 0: ack, 1: start pulse, 2: err pulse
    task automatic waitEv(input string name, input int kind, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(posedge clk);
            #2;
            case (kind)
                0:       hit = (ack_o != 4'b0000);
                1:       hit = tx_ctrl_o[0];
                default: hit = err_o;
            endcase
        end
        if (!hit) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL %s: no event within %0d cycles", name, budget);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        req_i = 4'b0000;
        cfg_par_en_i = 1'b0;
        cfg_par_odd_i = 1'b0;
        cfg_stop2_i = 1'b0;
        mdlHang = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        byteLog.delete();
    endtask

    task automatic chkResetVals(input string tag);
        chk({tag, "_ack"},   32'(ack_o),     32'h0);
        chk({tag, "_data"},  32'(tx_data_o), 32'h0);
        chk({tag, "_ctrl"},  32'(tx_ctrl_o), 32'h0);
        chk({tag, "_busy"},  32'(busy_o),    32'h0);
        chk({tag, "_grant"}, 32'(grant_o),   32'h0);
        chk({tag, "_err"},   32'(err_o),     32'h0);
        chk({tag, "_errch"}, 32'(err_ch_o),  32'h0);
    endtask

    initial begin
        int busyLow;
        int ackSnap;
        int ctrlBad;
        rst = 1'b1;
        req_i = 4'b0000;
        data_i = {8'hC3, 8'h3C, 8'h5A, 8'h11};
        cfg_par_en_i = 1'b0;
        cfg_par_odd_i = 1'b0;
        cfg_stop2_i = 1'b0;

        vecs[0]  = '{4'b1111, 0, 8'hA0, 8'h11};
        vecs[1]  = '{4'b1111, 1, 8'hA1, 8'h5A};
        vecs[2]  = '{4'b1111, 2, 8'hA2, 8'h3C};
        vecs[3]  = '{4'b1111, 3, 8'hA3, 8'hC3};
        vecs[4]  = '{4'b1111, 0, 8'hA0, 8'h11};
        vecs[5]  = '{4'b1111, 1, 8'hA1, 8'h5A};
        vecs[6]  = '{4'b1010, 3, 8'hA3, 8'hC3};
        vecs[7]  = '{4'b1010, 1, 8'hA1, 8'h5A};
        vecs[8]  = '{4'b1010, 3, 8'hA3, 8'hC3};
        vecs[9]  = '{4'b1010, 1, 8'hA1, 8'h5A};
        vecs[10] = '{4'b0100, 2, 8'hA2, 8'h3C};
        vecs[11] = '{4'b0001, 0, 8'hA0, 8'h11};

        // Single channel-2 frame with detailed timing checks.
        doReset();
        chkResetVals("reset");
        req_i = 4'b0100;
        @(posedge clk);
        #2;
        chk("a_start", 32'(tx_ctrl_o), 32'h1);
        chk("a_tag",   32'(tx_data_o), 32'hA2);
        chk("a_busy0", 32'(busy_o),    32'h1);
        req_i = 4'b0000;
        busyLow = 0;
        waitEv("a_ack", 0, 50);
        chk("a_ackvec", 32'(ack_o), 32'h4);
        chk("a_acklat", 32'(cyc), 32'(doneCyc + 1));
        chk("a_nbytes", 32'(byteLog.size()), 32'd2);
        if (byteLog.size() == 2) begin
            chk("a_byte0", 32'(byteLog[0]), 32'hA2);
            chk("a_byte1", 32'(byteLog[1]), 32'h3C);
        end
        @(posedge clk);
        #2;
        chk("a_ackgone", 32'(ack_o),  32'h0);
        chk("a_busyoff", 32'(busy_o), 32'h0);

        // Busy must stay high across the whole frame.
        doReset();
        req_i = 4'b0100;
        @(posedge clk);
        #2;
        for (int i = 0; i < 50 && ack_o == 4'b0000; i++) begin
            if (!busy_o) busyLow = busyLow + 1;
            @(posedge clk);
            #2;
        end
        chk("a_busyhold", 32'(busyLow), 32'd0);
        chk("a_busyack",  32'(busy_o),  32'h1);
        req_i = 4'b0000;
        repeat (2) @(posedge clk);

        // Round-robin table from a fresh reset.
        doReset();
        foreach (vecs[k]) begin
            req_i = vecs[k].req;
            waitEv($sformatf("rr%0d_ack", k), 0, 60);
            chk($sformatf("rr%0d_ackvec", k), 32'(ack_o),   32'(4'b0001 << vecs[k].ch));
            chk($sformatf("rr%0d_grant", k),  32'(grant_o), 32'(vecs[k].ch));
            chk($sformatf("rr%0d_nbytes", k), 32'(byteLog.size()), 32'd2);
            if (byteLog.size() == 2) begin
                chk($sformatf("rr%0d_tag", k),  32'(byteLog[0]), 32'(vecs[k].tag));
                chk($sformatf("rr%0d_data", k), 32'(byteLog[1]), 32'(vecs[k].dat));
            end
            byteLog.delete();
        end
        req_i = 4'b0000;
        repeat (3) @(posedge clk);

        // Cfg change mid-transfer is ignored until the next grant.
        req_i = 4'b0010;
        waitEv("c_start", 1, 20);
        repeat (2) @(posedge clk);
        #2;
        cfg_par_en_i = 1'b1;
        ctrlBad = 0;
        for (int i = 0; i < 50 && ack_o == 4'b0000; i++) begin
            if (tx_ctrl_o[3]) ctrlBad = ctrlBad + 1;
            @(posedge clk);
            #2;
        end
        chk("c_frozen", 32'(ctrlBad), 32'd0);
        waitEv("c_start2", 1, 20);
        chk("c_newcfg", 32'(tx_ctrl_o), 32'h9);
        req_i = 4'b0000;
        waitEv("c_ack2", 0, 50);
        chk("c_ackvec", 32'(ack_o), 32'h2);
        cfg_par_en_i = 1'b0;
        repeat (3) @(posedge clk);

        // Watchdog abort on channel 0, channel 1 served next, then 0 retried.
        doReset();
        mdlHang = 1'b1;
        ackSnap = ackCount;
        req_i = 4'b0011;
        waitEv("t_err", 2, 1200);
        chk("t_errcyc", 32'(cyc), 32'(startCyc + 1 + 1000));
        chk("t_errch", 32'(err_ch_o), 32'h0);
        chk("t_noack", 32'(ackCount), 32'(ackSnap));
        mdlHang = 1'b0;
        @(posedge clk);
        #2;
        chk("t_errpulse", 32'(err_o), 32'h0);
        waitEv("t_ack1", 0, 60);
        chk("t_next1", 32'(ack_o), 32'h2);
        waitEv("t_ack0", 0, 60);
        chk("t_retry0", 32'(ack_o), 32'h1);
        req_i = 4'b0000;
        repeat (3) @(posedge clk);

        // Reset while channel 3 waits for tx_done.
        req_i = 4'b1000;
        waitEv("r_start", 1, 20);
        chk("r_grant3", 32'(grant_o), 32'h3);
        repeat (2) @(posedge clk);
        #2;
        ackSnap = ackCount;
        rst = 1'b1;
        #1;
        chkResetVals("midrst");
        req_i = 4'b1111;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        waitEv("r_ack", 0, 60);
        chk("r_first0", 32'(ack_o), 32'h1);
        chk("r_noack3", 32'(ackCount), 32'(ackSnap));
        req_i = 4'b0000;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmitter (`txd`) among `NCH` acquisition channels. Each granted channel's byte is sent as a two-byte frame, tag then data, through the transmitter's `data_i`/`ctrl_i`/`TxReady`/`TxDone` handshake. A watchdog aborts hung transfers. It sits between the acquisition channels and the single `txd` instance.

## Interface
- `NCH`, 4: number of requesters, 2..16.
- `TAG_EN`, 1: 1 sends tag byte `{4'hA, ch[3:0]}` before data; 0 sends data byte only.
- `TMO_CYC`, 65535: watchdog limit in clk cycles per byte, ≥ 2, counter 16 bits.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_i` in NCH: per-channel request level.
- `data_i` in NCH*8: channel n byte at `[8n+7:8n]`.
- `ack_o` out NCH: one-cycle pulse, byte of channel n fully sent.
- `cfg_par_en_i`, `cfg_par_odd_i`, `cfg_stop2_i` in 1 each: frame format, sampled at grant.
- `tx_data_o` out 8: to `txd.data_i`.
- `tx_ctrl_o` out 4: to `txd.ctrl_i`, `{par_en, par_odd, stop2, start}`.
- `tx_ready_i` in 1: from `txd.TxReady`.
- `tx_done_i` in 1: from `txd.TxDone`, one-cycle pulse.
- `busy_o` out 1: high from grant through ACK or abort.
- `grant_o` out 4: index of current or last granted channel.
- `err_o` out 1: one-cycle watchdog pulse.
- `err_ch_o` out 4: channel aborted at the last `err_o`.

## Operation
- FSM states: `S_IDLE`, `S_START`, `S_LATCH`, `S_WAIT`, `S_ACK`.
- **S_IDLE**
  - If any `req_i` bit is set, grant the first requester searching from `ptr+1` cyclically.
  - Latch the channel index, its data byte and the three cfg bits.
  - Set `sel` = TAG if `TAG_EN`, else DATA. Go to `S_START`.
  - With no requests, stay in `S_IDLE`.
- **S_START**
  - Drive `tx_ctrl_o[0]=1` for exactly this cycle.
  - `tx_data_o` = tag or data per `sel`.
  - Clear the watchdog counter. Go to `S_LATCH`.
- **S_LATCH**: hold `tx_data_o`. On `tx_ready_i==0` (transmitter has captured the byte), go to `S_WAIT`.
- **S_WAIT**: on `tx_done_i`:
  - If `sel`=TAG, set `sel`=DATA and go to `S_START`.
  - Otherwise go to `S_ACK`.
- **S_ACK**: pulse `ack_o[grant]`, set `ptr`=grant, go to `S_IDLE`.
- **Watchdog**
  - Counts every cycle in `S_LATCH`/`S_WAIT`.
  - When the count reaches `TMO_CYC`: pulse `err_o`, set `err_ch_o`=grant, set `ptr`=grant, go to `S_IDLE`.
  - No ack is issued on abort. A still-asserted req is retried after the other channels have had a turn.
- **Requester contract**: `data_i[n]` must be stable while `req_i[n]` is high and unacked.
  - Data is captured at grant.
  - Dropping req mid-transfer does not abort the transfer; ack is still pulsed.
- Cfg bits are frozen from grant until return to `S_IDLE`; mid-transfer changes are ignored.
- `tx_ctrl_o[3:1]` always reflects the latched cfg. `tx_ctrl_o[0]` is high only in `S_START`.

## Timing
- **Reset values**:
  - `ack_o`=0, `tx_data_o`=0, `tx_ctrl_o`=0, `busy_o`=0, `grant_o`=0, `err_o`=0, `err_ch_o`=0.
  - `ptr`=NCH-1, so channel 0 wins first. State is `S_IDLE`.
- Reset mid-transfer: all of the above apply immediately and no ack is issued. The system resets `txd` from the same source.
- All outputs are registered.
- Request to start: `req_i` seen in `S_IDLE` at cycle t gives `tx_ctrl_o[0]` high at t+1.
- Inter-byte gap: `tx_done_i` at cycle t gives the next start pulse at t+1.
- `tx_done_i` at cycle t for the data byte gives `ack_o` at t+1, and the next grant is evaluated at t+2.
- Max grant rate: one channel per frame. A continuously asserting channel cannot starve others (strict round-robin).
- `tx_done_i` outside `S_WAIT` is ignored. `tx_ready_i` is sampled only in `S_LATCH`.

## Structure
- Package `uart_sched_pkg`:
  - FSM state encodings.
  - `TAG_HI=4'hA`.
  - `ctrl_i` bit positions (`CTRL_START=0`, `CTRL_STOP2=1`, `CTRL_PODD=2`, `CTRL_PEN=3`).
- Sub-module `rr_arbiter`:
  - Inputs: NCH-bit `req`, `ptr`.
  - Outputs: `gnt_idx` and `gnt_vld`.
  - Purely combinational search; the pointer register lives in `uart_tx_sched`.

## Test plan
- Channel 2 requests, `data_i` byte 0x3C, `TAG_EN=1`, `txd` behavioural model attached.
  - Expect `tx_data_o` 0xA2 then 0x3C, two start pulses.
  - Expect `ack_o=4'b0100` exactly one cycle after the second `tx_done_i`.
  - Expect `busy_o` high throughout.
- After reset, all four channels request together and stay asserted → service order 0,1,2,3,0,1…
- Channel 1 held high continuously, channel 3 requests → grants alternate 1,3,1,3.
- `TMO_CYC=1000`, model never pulses `tx_done_i` for channel 0.
  - Expect `err_o` pulse 1000 cycles after entering `S_LATCH`, with `err_ch_o`=0 and no ack.
  - With channel 1 also requesting, channel 1 is granted next.
- `cfg_par_en_i` toggled 0→1 during `S_WAIT` → `tx_ctrl_o[3]` stays 0 until the next grant, then is 1.
- `rst` asserted during `S_WAIT` of channel 3 → all outputs at reset values immediately; after release with all requesting, channel 0 is granted first.
